// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory arbiter.
//   state_t : arbiter FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//   owner_t : which requester owns the access in flight
//   ADDR_W_DEF / DATA_W_DEF : default word-address and data widths
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the word memory.
// Handshake: *_req is a level held (with its address/data) until the
// matching *_ack, which is a registered one-cycle pulse; the requester drops
// req in the ack cycle. Command fields are latched at grant, so later changes
// are ignored. mem_rdata is valid the cycle after the memory samples mem_addr.
//   slave  : arbiter view (drives acks, read data, memory command, dbg_state)
//   master : requester/memory/testbench view
interface mem_arbiter_if import mem_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [31:0]       ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_ack;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_misalign;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  state_t            dbg_state;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_ack, if_rdata, ls_ack, ls_rdata, ls_misalign,
           mem_addr, mem_we, mem_wdata, dbg_state
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_ack, if_rdata, ls_ack, ls_rdata, ls_misalign,
           mem_addr, mem_we, mem_wdata, dbg_state
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin grant.
//   clk, rst   : clock, asynchronous active-high reset
//   i_eligible : [0] = fetch, [1] = load/store
//   i_en       : grant allowed this cycle (arbiter idle)
//   o_grant    : one-hot grant, zero when nothing granted
// On a tie the side opposite the last grant wins; reset makes LS the last
// grant so fetch wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_eligible,
  input  logic       i_en,
  output logic [1:0] o_grant
);
  logic r_last_ls;

  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      case (i_eligible)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = r_last_ls ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_ls <= 1'b1;
    end else if (|o_grant) begin
      r_last_ls <= o_grant[1];
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one synchronous-read word memory between instruction fetch and
// load/store. Each access takes IDLE (grant, latch command) -> ACCESS (memory
// samples) -> RESP (read data valid, captured) and acks one cycle later.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_arbiter_if.slave (requesters, memory, dbg_state)
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  state_t            r_state;
  owner_t            r_owner;
  logic              r_we;
  logic              r_mis;
  logic              r_if_ack;
  logic              r_ls_ack;
  logic              r_ls_mis;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_ls_rdata;

  logic [1:0]        w_eligible;
  logic [1:0]        w_grant;
  logic              w_grant_en;
  logic              w_unused;

  // A requester is masked in its own ack cycle so a req still high from the
  // finished access does not start a duplicate one.
  assign w_eligible = {bus.ls_req & ~r_ls_ack, bus.if_req & ~r_if_ack};
  assign w_grant_en = (r_state == IDLE);

  // Address bits outside the word index are intentionally ignored.
  assign w_unused = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                      bus.ls_addr[31:ADDR_W+2]};

  rr_arb2 u_rr (
    .clk        (clk),
    .rst        (rst),
    .i_eligible (w_eligible),
    .i_en       (w_grant_en),
    .o_grant    (w_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_we        <= 1'b0;
      r_mis       <= 1'b0;
      r_if_ack    <= 1'b0;
      r_ls_ack    <= 1'b0;
      r_ls_mis    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_ls_ack <= 1'b0;
      r_ls_mis <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant[1]) begin
            r_owner     <= OWN_LS;
            r_we        <= bus.ls_we;
            r_mem_addr  <= bus.ls_addr[ADDR_W+1:2];
            r_mem_wdata <= bus.ls_wdata;
            r_mis       <= |bus.ls_addr[1:0];
            r_state     <= ACCESS;
          end else if (w_grant[0]) begin
            r_owner    <= OWN_IF;
            r_we       <= 1'b0;
            r_mem_addr <= bus.if_addr[ADDR_W+1:2];
            r_mis      <= 1'b0;
            r_state    <= ACCESS;
          end
        end
        ACCESS: r_state <= RESP;
        RESP: begin
          if (r_owner == OWN_IF) begin
            r_if_rdata <= bus.mem_rdata;
            r_if_ack   <= 1'b1;
          end else begin
            if (!r_we) r_ls_rdata <= bus.mem_rdata;
            r_ls_ack <= 1'b1;
            r_ls_mis <= r_mis;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Decoded from state so that reset removes the write strobe immediately.
  assign bus.mem_we      = (r_state == ACCESS) && r_we && (r_owner == OWN_LS);
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.if_ack      = r_if_ack;
  assign bus.if_rdata    = r_if_rdata;
  assign bus.ls_ack      = r_ls_ack;
  assign bus.ls_rdata    = r_ls_rdata;
  assign bus.ls_misalign = r_ls_mis;
  assign bus.dbg_state   = r_state;
endmodule
